alu_control_seq: RTL and testbench
==================================

// Module: alu_control_seq
// PURPOSE
//  Registered ALU control decoder with a built-in multiply/divide sequencer; next generation of the
//  combinational ALU control decode. Sits between the main control unit (ALU_op) and the ALU/MD unit.
//  Decodes ALU_op/funct into an ALU control word one cycle after acceptance, flags illegal functs,
//  and, for mult/div functs, launches the MD unit and back-pressures issue for MD_CYCLES cycles.
// PARAMETERS
//  CTRL_W     4   width of control_out (>=4); 4-bit codes zero-extended into upper bits
//  MD_CYCLES  32  cycles a mult/div occupies the MD unit (>=1)
//  (localparam CNT_W = $clog2(MD_CYCLES+1), width of the busy counter)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       synchronous reset, active-high
//  in_valid     in   1       ALU_op/funct valid this cycle
//  in_ready     out  1       1 = op accepted when in_valid; equals !md_busy
//  ALU_op       in   2       00 add, 01 sub, 10 R-type (use funct), 11 and
//  funct        in   6       R-type function field
//  out_valid    out  1       1-cycle pulse: control_out/illegal updated for the accepted op
//  control_out  out  CTRL_W  ALU control word (registered)
//  illegal      out  1       1-cycle pulse with out_valid: funct not decodable
//  md_start     out  1       1-cycle pulse: launch MD unit
//  md_op        out  2       MD operation = funct[1:0] (00 mult, 01 multu, 10 div, 11 divu)
//  md_busy      out  1       MD unit occupied
// BEHAVIOUR
//  - Reset values: control_out=0010, out_valid=0, illegal=0, md_start=0, md_op=00, md_busy=0,
//    counter=0, state=IDLE. rst wins over everything, including mid-busy: IDLE on the next edge.
//  - Accept = in_valid && in_ready. Latency 1: outputs registered on the accept edge, visible next cycle.
//  - Decode: ALU_op 00->0010, 01->0110, 11->0000, 10 by funct:
//    100000/100001 add(u)->0010; 100010/100011 sub(u)->0110; 100100 and->0000; 100101 or->0001;
//    100111 nor->1100; 101010/101011 slt(u)->0111; 0110xx mult/div->1111 (ALU pass/idle).
//  - Illegal funct (ALU_op=10, none of the above): out_valid=1, illegal=1, control_out HOLDS its
//    previous value; no MD launch.
//  - FSM IDLE: in_ready=1. Accepting a mult/div -> md_start=1 (one cycle), md_op=funct[1:0],
//    counter<=MD_CYCLES-1, md_busy=1, state MD_BUSY; out_valid pulses as for any other op.
//  - FSM MD_BUSY: in_ready=0, in_valid ignored (no state change, no out_valid). Counter decrements
//    each cycle; on the cycle counter==0, next state IDLE and md_busy=0. md_busy is high for exactly
//    MD_CYCLES cycles; first new op can be accepted in the cycle md_busy falls.
//  - MD_CYCLES=1: md_busy high one cycle only; counter never wraps (saturates at 0 in IDLE).
//  - Back-to-back non-MD ops: one accepted per cycle, out_valid stays high continuously.
//  - md_op holds last launched value until next launch or reset.
// CONFIGURATION
//  Macro ALU_CTRL_SHIFT_EN:
//   defined   -> ALU_op=10 also decodes 000000 sll->1000, 000010 srl->1001, 000011 sra->1010.
//   undefined -> those functs are illegal (illegal=1, control_out held).
// TESTING
//  1 Reset: assert rst 2 cycles -> control_out=0010, all other outputs 0, in_ready=1.
//  2 ALU_op=10 funct=101010 in_valid=1 one cycle -> next cycle out_valid=1 control_out=0111 illegal=0.
//  3 Illegal: after 2, send ALU_op=10 funct=111111 -> out_valid=1 illegal=1 control_out stays 0111.
//  4 MD: MD_CYCLES=4, send funct=011010 -> md_start 1 cycle, md_op=10, md_busy/in_ready=0 for 4
//    cycles; in_valid held with funct=100000 throughout -> accepted only when md_busy drops, then 0010.
//  5 Reset mid-busy: launch mult, assert rst at busy cycle 2 -> md_busy=0, in_ready=1 next cycle.
//  6 funct=000010 -> with ALU_CTRL_SHIFT_EN control_out=1001; without it illegal=1, control_out held.

Source files
------------

// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with a built-in multiply/divide issue sequencer.
// Optional macro ALU_CTRL_SHIFT_EN adds sll/srl/sra decode for R-type functs.
module alu_control_seq #(
   parameter int CTRL_W    = 4,
   parameter int MD_CYCLES = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        ALU_op,
   input  logic [5:0]        funct,
   output logic              out_valid,
   output logic [CTRL_W-1:0] control_out,
   output logic              illegal,
   output logic              md_start,
   output logic [1:0]        md_op,
   output logic              md_busy
);

   localparam int CNT_W = $clog2(MD_CYCLES + 1);

   typedef enum logic {IDLE, MD_BUSY} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_out_valid;
   logic             r_illegal;
   logic [3:0]       r_ctrl;
   logic             r_md_start;
   logic [1:0]       r_md_op;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_out_valid_nxt;
   logic             w_illegal_nxt;
   logic [3:0]       w_ctrl_nxt;
   logic             w_md_start_nxt;
   logic [1:0]       w_md_op_nxt;

   logic [3:0]       w_code;
   logic             w_legal;
   logic             w_is_md;
   logic             w_accept;

   // Pure decode of the presented op; only consumed on an accept edge.
   always_comb begin
      w_code  = 4'b0010;
      w_legal = 1'b1;
      w_is_md = 1'b0;
      case (ALU_op)
         2'b00: w_code = 4'b0010;
         2'b01: w_code = 4'b0110;
         2'b11: w_code = 4'b0000;
         default: begin
            casez (funct)
               6'b100000, 6'b100001: w_code = 4'b0010;
               6'b100010, 6'b100011: w_code = 4'b0110;
               6'b100100:            w_code = 4'b0000;
               6'b100101:            w_code = 4'b0001;
               6'b100111:            w_code = 4'b1100;
               6'b101010, 6'b101011: w_code = 4'b0111;
               6'b0110??: begin
                  w_code  = 4'b1111;
                  w_is_md = 1'b1;
               end
`ifdef ALU_CTRL_SHIFT_EN
               6'b000000:            w_code = 4'b1000;
               6'b000010:            w_code = 4'b1001;
               6'b000011:            w_code = 4'b1010;
`endif
               default:              w_legal = 1'b0;
            endcase
         end
      endcase
   end

   assign w_accept = in_valid && (r_state == IDLE);

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_ctrl_nxt      = r_ctrl;
      w_md_op_nxt     = r_md_op;
      w_md_start_nxt  = 1'b0;
      w_out_valid_nxt = w_accept;
      w_illegal_nxt   = w_accept && !w_legal;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               // Illegal functs report but leave the control word untouched.
               if (w_legal) w_ctrl_nxt = w_code;
               if (w_is_md) begin
                  w_md_start_nxt = 1'b1;
                  w_md_op_nxt    = funct[1:0];
                  w_cnt_nxt      = CNT_W'(MD_CYCLES - 1);
                  w_state_nxt    = MD_BUSY;
               end
            end
         end
         MD_BUSY: begin
            if (r_cnt == '0) w_state_nxt = IDLE;
            else             w_cnt_nxt   = r_cnt - 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_illegal   <= 1'b0;
         r_ctrl      <= 4'b0010;
         r_md_start  <= 1'b0;
         r_md_op     <= 2'b00;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_illegal   <= w_illegal_nxt;
         r_ctrl      <= w_ctrl_nxt;
         r_md_start  <= w_md_start_nxt;
         r_md_op     <= w_md_op_nxt;
      end
   end

   assign md_busy     = (r_state == MD_BUSY);
   assign in_ready    = !md_busy;
   assign out_valid   = r_out_valid;
   assign illegal     = r_illegal;
   assign control_out = CTRL_W'(r_ctrl);
   assign md_start    = r_md_start;
   assign md_op       = r_md_op;

endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq: stimulus pushes expected decode results,
// a negedge monitor pops and compares on every out_valid.
module tb_alu_control_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] ALU_op;
   logic [5:0] funct;
   logic       out_valid;
   logic [3:0] control_out;
   logic       illegal;
   logic       md_start;
   logic [1:0] md_op;
   logic       md_busy;

   alu_control_seq #(.CTRL_W(4), .MD_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .ALU_op(ALU_op), .funct(funct), .out_valid(out_valid),
      .control_out(control_out), .illegal(illegal), .md_start(md_start),
      .md_op(md_op), .md_busy(md_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] ctrl;
      logic       ill;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   logic [3:0] exp_ctrl;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Drive one op and push its expected response (illegal ops hold the control word).
   task automatic send(input logic [1:0] op, input logic [5:0] f, input logic [3:0] code, input logic ill);
      exp_t e;
      ALU_op   = op;
      funct    = f;
      in_valid = 1'b1;
      if (!ill) exp_ctrl = code;
      e.ctrl = exp_ctrl;
      e.ill  = ill;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out_valid: got 1 expected 0");
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("mon_control_out", 32'(control_out), 32'(e.ctrl));
            chk("mon_illegal", 32'(illegal), 32'(e.ill));
         end
      end
   end

   typedef struct {
      logic [1:0] op;
      logic [5:0] f;
      logic [3:0] code;
      logic       ill;
   } vec_t;

   vec_t vecs[$];

   initial begin
      rst = 1'b1; in_valid = 1'b0; ALU_op = 2'b00; funct = 6'b0;
      exp_ctrl = 4'b0010;
      cyc(); cyc();
      chk("rst_control_out", 32'(control_out), 32'h2);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_illegal", 32'(illegal), 0);
      chk("rst_md_start", 32'(md_start), 0);
      chk("rst_md_op", 32'(md_op), 0);
      chk("rst_md_busy", 32'(md_busy), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      rst = 1'b0;

      // Back-to-back non-MD ops, including an illegal funct that must hold 0111.
      vecs = '{
         '{2'b00, 6'b000000, 4'b0010, 1'b0}, '{2'b01, 6'b111111, 4'b0110, 1'b0},
         '{2'b11, 6'b000000, 4'b0000, 1'b0}, '{2'b10, 6'b100000, 4'b0010, 1'b0},
         '{2'b10, 6'b100001, 4'b0010, 1'b0}, '{2'b10, 6'b100010, 4'b0110, 1'b0},
         '{2'b10, 6'b100011, 4'b0110, 1'b0}, '{2'b10, 6'b100100, 4'b0000, 1'b0},
         '{2'b10, 6'b100101, 4'b0001, 1'b0}, '{2'b10, 6'b100111, 4'b1100, 1'b0},
         '{2'b10, 6'b101011, 4'b0111, 1'b0}, '{2'b10, 6'b101010, 4'b0111, 1'b0},
         '{2'b10, 6'b111111, 4'b0000, 1'b1}, '{2'b10, 6'b100110, 4'b0000, 1'b1}
      };
      foreach (vecs[i]) begin
         send(vecs[i].op, vecs[i].f, vecs[i].code, vecs[i].ill);
         cyc();
         chk("b2b_out_valid", 32'(out_valid), 1);
      end
      in_valid = 1'b0;
      cyc();
      chk("idle_out_valid", 32'(out_valid), 0);
      chk("hold_after_illegal", 32'(control_out), 32'h7);

      // Shift functs: legal only with the shift option compiled in.
`ifdef ALU_CTRL_SHIFT_EN
      send(2'b10, 6'b000010, 4'b1001, 1'b0); cyc();
      send(2'b10, 6'b000000, 4'b1000, 1'b0); cyc();
      send(2'b10, 6'b000011, 4'b1010, 1'b0); cyc();
`else
      send(2'b10, 6'b000010, 4'b0000, 1'b1); cyc();
      send(2'b10, 6'b000000, 4'b0000, 1'b1); cyc();
      send(2'b10, 6'b000011, 4'b0000, 1'b1); cyc();
`endif
      in_valid = 1'b0;
      cyc();

      // div launch; a held add must wait out all 4 busy cycles.
      send(2'b10, 6'b011010, 4'b1111, 1'b0);
      cyc();
      chk("md_start_pulse", 32'(md_start), 1);
      chk("md_op_div", 32'(md_op), 2);
      chk("md_busy_c1", 32'(md_busy), 1);
      chk("in_ready_c1", 32'(in_ready), 0);
      send(2'b10, 6'b100000, 4'b0010, 1'b0);
      for (int k = 2; k <= 4; k++) begin
         cyc();
         chk("md_start_low", 32'(md_start), 0);
         chk("md_busy_hold", 32'(md_busy), 1);
         chk("in_ready_low", 32'(in_ready), 0);
         chk("busy_no_out_valid", 32'(out_valid), 0);
      end
      cyc();
      chk("md_busy_fall", 32'(md_busy), 0);
      chk("in_ready_rise", 32'(in_ready), 1);
      chk("fall_no_out_valid", 32'(out_valid), 0);
      cyc();
      in_valid = 1'b0;
      chk("held_op_accepted", 32'(out_valid), 1);
      chk("md_op_held", 32'(md_op), 2);
      cyc();
      chk("single_accept", 32'(out_valid), 0);

      // multu launch, reset during the second busy cycle.
      send(2'b10, 6'b011001, 4'b1111, 1'b0);
      cyc();
      in_valid = 1'b0;
      chk("md_op_multu", 32'(md_op), 1);
      cyc();
      chk("busy_before_rst", 32'(md_busy), 1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      exp_ctrl = 4'b0010;
      chk("rst_mid_md_busy", 32'(md_busy), 0);
      chk("rst_mid_in_ready", 32'(in_ready), 1);
      chk("rst_mid_control", 32'(control_out), 32'h2);
      chk("rst_mid_md_op", 32'(md_op), 0);

      send(2'b01, 6'b000000, 4'b0110, 1'b0);
      cyc();
      in_valid = 1'b0;
      cyc(); cyc();
      chk("scoreboard_drained", 32'(q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
